// File: rtl/jserial_alu_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial ADD/CMP unit.
// The sequencer uses the master side; the serial engine uses the slave side.
interface jserial_alu_if #(
    parameter int unsigned N = 8
) ();
    logic         start;
    logic         mode;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [N-1:0] c;
    logic         co;
    logic         eqo;
    logic         alo;

    modport master (
        output start, mode, a, b, ci,
        input  busy, done, c, co, eqo, alo
    );

    modport slave (
        input  start, mode, a, b, ci,
        output busy, done, c, co, eqo, alo
    );
endinterface

// File: rtl/jserial_alu.sv
// Bit-serial N-bit ADD/CMP engine: one shared adder/comparator slice, one bit per clock.
// ADD runs LSB-first, CMP runs MSB-first; results hold from done until the next accept.
module jserial_alu #(
    parameter int unsigned N = 8
) (
    input logic           clk,
    input logic           reset_n,
    jserial_alu_if.slave  bus
);
    localparam int unsigned   CW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LastIdx = CW'(N - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          mode_q;
    logic [N-1:0]  a_q, b_q, c_q;
    logic          carry_q, eq_q, al_q;
    logic          done_q, co_q, eqo_q, alo_q;

    logic          accept, last;
    logic [CW-1:0] idx;
    logic          abit, bbit, res_bit;
    logic          carry_d, eq_d, al_d;

    assign accept = (state_q == StIdle) && bus.start;
    assign last   = (state_q == StRun) && (cnt_q == LastIdx);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.start) state_d = StRun;
            StRun:  if (cnt_q == LastIdx) state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == StRun);
        bus.done = done_q;
        bus.c    = c_q;
        bus.co   = co_q;
        bus.eqo  = eqo_q;
        bus.alo  = alo_q;
    end

    // Shared bit slice; CMP walks the operands from the MSB down.
    always_comb begin
        idx     = mode_q ? (LastIdx - cnt_q) : cnt_q;
        abit    = a_q[idx];
        bbit    = b_q[idx];
        res_bit = abit ^ bbit ^ (carry_q & ~mode_q);
        carry_d = (abit & bbit) | (carry_q & (abit ^ bbit));
        al_d    = al_q | (eq_q & abit & ~bbit);
        eq_d    = eq_q & ~(abit ^ bbit);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            carry_q <= 1'b0;
            eq_q    <= 1'b0;
            al_q    <= 1'b0;
            done_q  <= 1'b0;
            co_q    <= 1'b0;
            eqo_q   <= 1'b0;
            alo_q   <= 1'b0;
        end else begin
            done_q <= last;
            if (accept) begin
                cnt_q   <= '0;
                mode_q  <= bus.mode;
                a_q     <= bus.a;
                b_q     <= bus.b;
                carry_q <= bus.ci & ~bus.mode;
                eq_q    <= 1'b1;
                al_q    <= 1'b0;
            end else if (state_q == StRun) begin
                c_q[idx] <= res_bit;
                carry_q  <= carry_d;
                eq_q     <= eq_d;
                al_q     <= al_d;
                cnt_q    <= cnt_q + 1'b1;
                if (last) begin
                    co_q  <= ~mode_q & carry_d;
                    eqo_q <= mode_q & eq_d;
                    alo_q <= mode_q & al_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_jserial_alu.sv
// Self-checking bench for jserial_alu: directed handshake/reset steps at N=8 plus
// randomized ADD/CMP sweeps at N=2, 5 and 16 against an arithmetic reference.
module tb_jserial_alu;
    logic        clk = 1'b0;
    logic        reset_n;
    int          sel;
    logic        start_s, mode_s, ci_s;
    logic [15:0] a_s, b_s;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    jserial_alu_if #(.N(8))  if8  ();
    jserial_alu_if #(.N(2))  if2  ();
    jserial_alu_if #(.N(5))  if5  ();
    jserial_alu_if #(.N(16)) if16 ();

    jserial_alu #(.N(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(if8.slave));
    jserial_alu #(.N(2))  dut2  (.clk(clk), .reset_n(reset_n), .bus(if2.slave));
    jserial_alu #(.N(5))  dut5  (.clk(clk), .reset_n(reset_n), .bus(if5.slave));
    jserial_alu #(.N(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(if16.slave));

    assign if8.start  = start_s && (sel == 0);
    assign if2.start  = start_s && (sel == 1);
    assign if5.start  = start_s && (sel == 2);
    assign if16.start = start_s && (sel == 3);
    assign if8.mode   = mode_s;
    assign if2.mode   = mode_s;
    assign if5.mode   = mode_s;
    assign if16.mode  = mode_s;
    assign if8.ci     = ci_s;
    assign if2.ci     = ci_s;
    assign if5.ci     = ci_s;
    assign if16.ci    = ci_s;
    assign if8.a      = a_s[7:0];
    assign if8.b      = b_s[7:0];
    assign if2.a      = a_s[1:0];
    assign if2.b      = b_s[1:0];
    assign if5.a      = a_s[4:0];
    assign if5.b      = b_s[4:0];
    assign if16.a     = a_s;
    assign if16.b     = b_s;

    logic        busy_m, done_m, co_m, eqo_m, alo_m;
    logic [15:0] c_m;

    always_comb begin
        busy_m = 1'b0; done_m = 1'b0; co_m = 1'b0; eqo_m = 1'b0; alo_m = 1'b0; c_m = '0;
        case (sel)
            0: begin busy_m = if8.busy;  done_m = if8.done;  c_m = 16'(if8.c);
                     co_m = if8.co;  eqo_m = if8.eqo;  alo_m = if8.alo;  end
            1: begin busy_m = if2.busy;  done_m = if2.done;  c_m = 16'(if2.c);
                     co_m = if2.co;  eqo_m = if2.eqo;  alo_m = if2.alo;  end
            2: begin busy_m = if5.busy;  done_m = if5.done;  c_m = 16'(if5.c);
                     co_m = if5.co;  eqo_m = if5.eqo;  alo_m = if5.alo;  end
            default: begin busy_m = if16.busy; done_m = if16.done; c_m = if16.c;
                     co_m = if16.co; eqo_m = if16.eqo; alo_m = if16.alo; end
        endcase
    end

    function automatic int width_of(input int s);
        case (s)
            0:       return 8;
            1:       return 2;
            2:       return 5;
            default: return 16;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Launches one operation and checks latency, handshake and results against plain arithmetic.
    task automatic run_op(input int s, input logic m, input logic [15:0] a, input logic [15:0] b,
                          input logic c_in, input string tag);
        int          w, lat;
        bit          early;
        logic [31:0] mask, ax, bx, full, exp_c;
        logic        exp_co, exp_eq, exp_al;
        w    = width_of(s);
        mask = (32'd1 << w) - 32'd1;
        ax   = 32'(a) & mask;
        bx   = 32'(b) & mask;
        if (!m) begin
            full   = ax + bx + 32'(c_in);
            exp_c  = full & mask;
            exp_co = full[w];
            exp_eq = 1'b0;
            exp_al = 1'b0;
        end else begin
            exp_c  = ax ^ bx;
            exp_co = 1'b0;
            exp_eq = (ax == bx);
            exp_al = (ax > bx);
        end
        sel = s; mode_s = m; a_s = a; b_s = b; ci_s = c_in; start_s = 1'b1;
        cycle();
        start_s = 1'b0;
        check({tag, " busy_after_accept"}, 32'(busy_m), 32'd1);
        lat = 0; early = 1'b0;
        while (!done_m && lat < w + 2) begin
            if (!busy_m) early = 1'b1;
            cycle();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(w));
        check({tag, " busy_gap"}, 32'(early), 32'd0);
        check({tag, " busy_at_done"}, 32'(busy_m), 32'd0);
        check({tag, " c"}, 32'(c_m), exp_c);
        check({tag, " co"}, 32'(co_m), 32'(exp_co));
        check({tag, " eqo"}, 32'(eqo_m), 32'(exp_eq));
        check({tag, " alo"}, 32'(alo_m), 32'(exp_al));
        cycle();
        check({tag, " done_single"}, 32'(done_m), 32'd0);
    endtask

    initial begin
        int  lat;
        bit  seen;
        logic        rm, rci;
        logic [15:0] ra, rb;

        sel = 0; start_s = 1'b0; mode_s = 1'b0; ci_s = 1'b0; a_s = '0; b_s = '0;
        reset_n = 1'b0;
        cycle();
        cycle();
        check("rst busy", 32'(busy_m), 32'd0);
        check("rst done", 32'(done_m), 32'd0);
        check("rst c", 32'(c_m), 32'd0);
        check("rst co", 32'(co_m), 32'd0);
        check("rst eqo", 32'(eqo_m), 32'd0);
        check("rst alo", 32'(alo_m), 32'd0);
        reset_n = 1'b1;
        cycle();

        run_op(0, 1'b0, 16'h5A, 16'h3C, 1'b0, "add_5a_3c");
        check("add_5a_3c c_const", 32'(c_m), 32'h96);
        run_op(0, 1'b0, 16'hFF, 16'h01, 1'b1, "add_ff_01_ci");
        a_s = '0; b_s = '0; ci_s = 1'b0;
        repeat (3) cycle();
        check("hold c", 32'(c_m), 32'h01);
        check("hold co", 32'(co_m), 32'd1);
        run_op(0, 1'b1, 16'h80, 16'h7F, 1'b0, "cmp_80_7f");
        run_op(0, 1'b1, 16'hA5, 16'hA5, 1'b1, "cmp_a5_a5");
        run_op(0, 1'b1, 16'h10, 16'h11, 1'b0, "cmp_10_11");

        // Start during RUN is ignored; start in the done cycle is accepted.
        sel = 0; mode_s = 1'b0; a_s = 16'h12; b_s = 16'h34; ci_s = 1'b0; start_s = 1'b1;
        cycle();
        start_s = 1'b0;
        cycle();
        cycle();
        mode_s = 1'b1; a_s = 16'hFF; b_s = 16'h00; start_s = 1'b1;
        cycle();
        start_s = 1'b0;
        check("hs busy_mid", 32'(busy_m), 32'd1);
        lat = 3;
        while (!done_m && lat < 12) begin cycle(); lat++; end
        check("hs first_latency", 32'(lat), 32'd8);
        check("hs first_c", 32'(c_m), 32'h46);
        check("hs first_eqo", 32'(eqo_m), 32'd0);
        mode_s = 1'b1; a_s = 16'h80; b_s = 16'h7F; start_s = 1'b1;
        cycle();
        start_s = 1'b0;
        check("hs b2b_busy", 32'(busy_m), 32'd1);
        lat = 0;
        while (!done_m && lat < 12) begin cycle(); lat++; end
        check("hs b2b_latency", 32'(lat), 32'd8);
        check("hs b2b_c", 32'(c_m), 32'hFF);
        check("hs b2b_alo", 32'(alo_m), 32'd1);
        check("hs b2b_co", 32'(co_m), 32'd0);
        cycle();

        // Reset part-way through RUN aborts the operation.
        sel = 0; mode_s = 1'b0; a_s = 16'h33; b_s = 16'h44; ci_s = 1'b0; start_s = 1'b1;
        cycle();
        start_s = 1'b0;
        repeat (3) cycle();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        check("abort busy", 32'(busy_m), 32'd0);
        check("abort done", 32'(done_m), 32'd0);
        check("abort c", 32'(c_m), 32'd0);
        check("abort alo", 32'(alo_m), 32'd0);
        seen = 1'b0;
        repeat (10) begin
            if (done_m) seen = 1'b1;
            cycle();
        end
        check("abort no_done", 32'(seen), 32'd0);
        run_op(0, 1'b0, 16'h01, 16'h01, 1'b0, "post_rst_add");

        run_op(2, 1'b0, 16'h1F, 16'h1F, 1'b1, "n5_corner");
        check("n5_corner c_const", 32'(c_m), 32'h1F);
        check("n5_corner co_const", 32'(co_m), 32'd1);

        for (int s = 1; s <= 3; s++) begin
            for (int i = 0; i < 200; i++) begin
                rm  = 1'($urandom_range(0, 1));
                rci = 1'($urandom_range(0, 1));
                ra  = 16'($urandom);
                rb  = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
                run_op(s, rm, ra, rb, rci, $sformatf("rand_n%0d_%0d", width_of(s), i));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
